// File: rtl/change_select_pkg.sv
// Shared types and defaults for the change-driven select counter.
// Optional build macro: CHANGE_SELECT_MASK_EN (adds a compare mask port).
package change_select_pkg;

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int DEF_DATA_W  = 24;
  localparam int DEF_SEL_W   = 3;
  localparam int DEF_SEL_MAX = 7;
  localparam int DEF_HOLDOFF = 0;

  // Down-counter width able to hold HOLDOFF-1; never narrower than one bit.
  function automatic int hold_cnt_w(input int holdoff);
    int w;
    w = $clog2(holdoff + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/holdoff_timer.sv
// Hold-off window after a counted change: busy stays high for exactly
// HOLDOFF cycles following start. HOLDOFF=0 never leaves IDLE.
module holdoff_timer
  import change_select_pkg::*;
#(
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic busy
);

  localparam int CW = hold_cnt_w(HOLDOFF);
  localparam logic [CW-1:0] LOAD = (HOLDOFF > 0) ? CW'(HOLDOFF - 1) : '0;

  state_t state;
  logic [CW-1:0] cnt;

  // The start edge itself is the first window cycle, so load HOLDOFF-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (HOLDOFF > 0)) begin
            state <= HOLD;
            cnt   <= LOAD;
            busy  <= 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/change_select_counter.sv
// Advances a select index once per detected change on bus A, with wrap at
// SEL_MAX, optional hold-off, enable and clear. Macro: CHANGE_SELECT_MASK_EN.
module change_select_counter
  import change_select_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int SEL_MAX = DEF_SEL_MAX,
  parameter int HOLDOFF = DEF_HOLDOFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [DATA_W-1:0] A,
`ifdef CHANGE_SELECT_MASK_EN
  input  logic [DATA_W-1:0] mask,
`endif
  output logic [SEL_W-1:0]  sel,
  output logic              change,
  output logic              wrap,
  output logic              busy
);

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SEL_MAX);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] cmp;
  logic              primed;
  logic              diff;
  logic              count;

`ifdef CHANGE_SELECT_MASK_EN
  assign cmp = (A ^ a_q) & ~mask;
`else
  assign cmp = A ^ a_q;
`endif

  // Nothing is counted until a_q holds a real sample (primed).
  assign diff  = primed && (cmp != '0);
  assign count = diff && en && !clear && !busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      primed <= 1'b0;
      change <= 1'b0;
      sel    <= '0;
      wrap   <= 1'b0;
    end else begin
      a_q    <= A;
      primed <= 1'b1;
      change <= diff;
      if (clear) begin
        sel  <= '0;
        wrap <= 1'b0;
      end else if (count) begin
        sel  <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
        wrap <= (sel == SEL_LAST);
      end else begin
        wrap <= 1'b0;
      end
    end
  end

  holdoff_timer #(.HOLDOFF(HOLDOFF)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .start (count),
    .clear (clear),
    .busy  (busy)
  );

endmodule
